// File: rtl/detector_pkg.sv
// Shared constants for detector_flancos: edge-mode codes, repeat-state encoding, helpers.
package detector_pkg;

  localparam int unsigned MODO_SUBIDA = 0;
  localparam int unsigned MODO_BAJADA = 1;
  localparam int unsigned MODO_AMBOS  = 2;

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    ESPERA = 2'd1,
    REPITE = 2'd2
  } estado_rep_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/canal_impulso.sv
// One button channel: edge detector producing a one-cycle impulse, with optional
// auto-repeat while the active level is held (enabled by macro AUTO_REPEAT_EN).
module canal_impulso
  import detector_pkg::*;
#(
  parameter int unsigned MODO        = 0,
  parameter int unsigned RETARDO_REP = 500,
  parameter int unsigned PERIODO_REP = 100
) (
  input  logic clock1k,
  input  logic reset,
  input  logic i_boton,
  output logic o_impulso,
  output logic o_impulso_sig_c
);

  if (MODO > MODO_AMBOS || RETARDO_REP < 2 || PERIODO_REP < 2) begin : g_param_invalid
    $error("canal_impulso: invalid MODO/RETARDO_REP/PERIODO_REP");
  end

  logic r_valor_antiguo;
  logic r_impulso;
  logic w_subida;
  logic w_bajada;
  logic w_flanco;
  logic w_impulso_sig;

  assign w_subida = i_boton & ~r_valor_antiguo;
  assign w_bajada = ~i_boton & r_valor_antiguo;
  assign w_flanco = (MODO == MODO_SUBIDA) ? w_subida :
                    (MODO == MODO_BAJADA) ? w_bajada : (w_subida | w_bajada);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CNT_MAX = max_u(RETARDO_REP, PERIODO_REP);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  estado_rep_t r_estado, w_estado_sig;
  logic [CW-1:0] r_cnt, w_cnt_sig;
  logic w_activo;
  logic w_puede_repetir;

  assign w_activo        = (MODO == MODO_BAJADA) ? ~i_boton : i_boton;
  assign w_puede_repetir = (MODO != MODO_AMBOS);

  // Next-state: a fresh edge restarts the delay; dropping the active level cancels at once.
  always_comb begin
    w_estado_sig  = r_estado;
    w_cnt_sig     = (r_cnt == CW'(CNT_MAX)) ? r_cnt : r_cnt + CW'(1);
    w_impulso_sig = 1'b0;
    if (w_flanco) begin
      w_impulso_sig = 1'b1;
      w_cnt_sig     = '0;
      w_estado_sig  = w_puede_repetir ? ESPERA : LIBRE;
    end else begin
      case (r_estado)
        LIBRE: ;
        ESPERA: begin
          if (!w_activo) begin
            w_estado_sig = LIBRE;
          end else if (r_cnt == CW'(RETARDO_REP - 1)) begin
            w_impulso_sig = 1'b1;
            w_cnt_sig     = '0;
            w_estado_sig  = REPITE;
          end
        end
        REPITE: begin
          if (!w_activo) begin
            w_estado_sig = LIBRE;
          end else if (r_cnt == CW'(PERIODO_REP - 1)) begin
            w_impulso_sig = 1'b1;
            w_cnt_sig     = '0;
          end
        end
        default: w_estado_sig = LIBRE;
      endcase
    end
  end

  always_ff @(negedge clock1k) begin
    if (reset) begin
      r_estado <= LIBRE;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_cnt    <= w_cnt_sig;
    end
  end
`else
  assign w_impulso_sig = w_flanco;
`endif

  always_ff @(negedge clock1k) begin
    if (reset) begin
      r_valor_antiguo <= 1'b0;
      r_impulso       <= 1'b0;
    end else begin
      r_valor_antiguo <= i_boton;
      r_impulso       <= w_impulso_sig;
    end
  end

  assign o_impulso       = r_impulso;
  assign o_impulso_sig_c = w_impulso_sig;

endmodule

// File: rtl/detector_flancos.sv
// Multi-channel button edge detector; optional auto-repeat via macro AUTO_REPEAT_EN.
module detector_flancos
  import detector_pkg::*;
#(
  parameter int unsigned CANALES     = 4,
  parameter int unsigned MODO        = MODO_SUBIDA,
  parameter int unsigned RETARDO_REP = 500,
  parameter int unsigned PERIODO_REP = 100
) (
  input  logic               clock1k,
  input  logic               reset,
  input  logic [CANALES-1:0] botonLimpio,
  output logic [CANALES-1:0] impulso,
  output logic               cualquiera
);

  if (CANALES < 1 || CANALES > 16) begin : g_canales_invalid
    $error("detector_flancos: CANALES must be 1..16");
  end

  logic [CANALES-1:0] w_impulso_sig;
  logic               r_cualquiera;

  for (genvar g = 0; g < CANALES; g++) begin : g_canal
    canal_impulso #(
      .MODO        (MODO),
      .RETARDO_REP (RETARDO_REP),
      .PERIODO_REP (PERIODO_REP)
    ) u_canal (
      .clock1k         (clock1k),
      .reset           (reset),
      .i_boton         (botonLimpio[g]),
      .o_impulso       (impulso[g]),
      .o_impulso_sig_c (w_impulso_sig[g])
    );
  end

  // Built from next-state impulses so it lands in the same cycle as impulso.
  always_ff @(negedge clock1k) begin
    if (reset) r_cualquiera <= 1'b0;
    else       r_cualquiera <= |w_impulso_sig;
  end

  assign cualquiera = r_cualquiera;

endmodule

// File: tb/tb_detector_flancos.sv
// Scoreboard bench for detector_flancos: three instances (rising, falling, both edges).
module tb_detector_flancos;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b0, b1, b2;
  logic [3:0] imp0, imp1, imp2;
  logic       cq0, cq1, cq2;

  int n_chk  = 0;
  int n_fail = 0;
  int ciclo  = 0;

  typedef struct packed {
    logic [3:0] e0;
    logic [3:0] e1;
    logic [3:0] e2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  detector_flancos #(.CANALES(4), .MODO(0), .RETARDO_REP(5), .PERIODO_REP(3)) u_m0 (
    .clock1k(clk), .reset(rst), .botonLimpio(b0), .impulso(imp0), .cualquiera(cq0));
  detector_flancos #(.CANALES(4), .MODO(1), .RETARDO_REP(5), .PERIODO_REP(3)) u_m1 (
    .clock1k(clk), .reset(rst), .botonLimpio(b1), .impulso(imp1), .cualquiera(cq1));
  detector_flancos #(.CANALES(4), .MODO(2), .RETARDO_REP(5), .PERIODO_REP(3)) u_m2 (
    .clock1k(clk), .reset(rst), .botonLimpio(b2), .impulso(imp2), .cualquiera(cq2));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, ciclo, act, req);
    end
  endtask

  // Monitor: outputs settle on the falling edge; sample on the rising edge.
  always @(posedge clk) begin
    exp_t e;
    ciclo++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("impulso_m0", imp0, e.e0);
      chk("cualquiera_m0", {3'b000, cq0}, {3'b000, |e.e0});
      chk("impulso_m1", imp1, e.e1);
      chk("cualquiera_m1", {3'b000, cq1}, {3'b000, |e.e1});
      chk("impulso_m2", imp2, e.e2);
      chk("cualquiera_m2", {3'b000, cq2}, {3'b000, |e.e2});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next falling edge.
  task automatic step(input logic r,
                      input logic [3:0] i0, input logic [3:0] x0,
                      input logic [3:0] i1, input logic [3:0] x1,
                      input logic [3:0] i2, input logic [3:0] x2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    b0  = i0;
    b1  = i1;
    b2  = i2;
    e.e0 = x0;
    e.e1 = x1;
    e.e2 = x2;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0  = '0;
    b1  = '0;
    b2  = '0;
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Basic edges in each mode, multi-channel coincidence.
    step(0, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b0010);
    step(0, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b1001, 4'b1001, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b1001, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0000);
    step(0, 4'b0110, 4'b0110, 4'b1111, 4'b0000, 4'b0010, 4'b0000);
    step(0, 4'b0110, 4'b0000, 4'b0110, 4'b1001, 4'b0010, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0010);
    step(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1100, 4'b1100);
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 4'b1000);

    // Reset overrides new edges; levels held through release re-trigger.
    step(0, 4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0100, 4'b0000);
    step(1, 4'b0011, 4'b0000, 4'b1110, 4'b0000, 4'b0101, 4'b0000);
    step(1, 4'b0011, 4'b0000, 4'b1111, 4'b0000, 4'b0101, 4'b0000);
    step(0, 4'b0011, 4'b0011, 4'b1111, 4'b0000, 4'b0101, 4'b0101);
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101);

`ifdef AUTO_REPEAT_EN
    // Held 15 cycles: impulses at t, t+5, t+8, t+11, t+14.
    for (int k = 1; k <= 15; k++) begin
      logic hit;
      hit = (k == 1 || k == 6 || k == 9 || k == 12 || k == 15);
      step(0, 4'b1000, hit ? 4'b1000 : 4'b0000, 4'b1110, hit ? 4'b0001 : 4'b0000,
           4'b0000, 4'b0000);
    end
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    // Release sampled on the cycle a repeat is due: no impulse.
    for (int k = 1; k <= 14; k++) begin
      logic hit;
      hit = (k == 1 || k == 6 || k == 9 || k == 12);
      step(0, 4'b1000, hit ? 4'b1000 : 4'b0000, 4'b1110, hit ? 4'b0001 : 4'b0000,
           4'b0000, 4'b0000);
    end
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    // Reset while repeating with the button held.
    for (int k = 1; k <= 7; k++) begin
      logic hit;
      hit = (k == 1 || k == 6);
      step(0, 4'b0001, hit ? 4'b0001 : 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    step(1, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    step(1, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      logic hit;
      hit = (k == 1 || k == 6);
      step(0, 4'b0001, hit ? 4'b0001 : 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
`else
    // Without auto-repeat a long hold yields a single impulse.
    for (int k = 1; k <= 10; k++) begin
      step(0, 4'b1000, (k == 1) ? 4'b1000 : 4'b0000, 4'b1110, (k == 1) ? 4'b0001 : 4'b0000,
           4'b0000, 4'b0000);
    end
    step(0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
`endif

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_flancos.md
DETECTOR_FLANCOS -- requirements
Module: detector_flancos

Interface
REQ-001 Parameter CANALES, default 4: number of independent button channels, 1..16.
REQ-002 Parameter MODO, default 0: 0 = rising edge, 1 = falling edge, 2 = both edges.
REQ-003 Parameter RETARDO_REP, default 500: cycles from the initial impulse to the first repeat impulse; must be >= 2.
REQ-004 Parameter PERIODO_REP, default 100: cycles between successive repeat impulses; must be >= 2.
REQ-005 Port clock1k, input, 1 bit: the single clock; all registers update on its falling edge.
REQ-006 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port botonLimpio, input, CANALES bits: debounced button levels, one bit per channel.
REQ-008 Port impulso, output, CANALES bits: registered one-cycle impulse per channel.
REQ-009 Port cualquiera, output, 1 bit: registered OR of all next-state impulso bits, aligned with impulso.

Function
REQ-010 Each channel SHALL hold a registered previous-level bit valorAntiguo[i], updated to botonLimpio[i] every cycle.
REQ-011 Edge detection: rising = valorAntiguo 0 and input 1; falling = valorAntiguo 1 and input 0; MODO 2 accepts either.
REQ-012 impulso[i] SHALL be 1 on the clock edge at which a qualifying edge is sampled, and 0 on the following edge unless a new qualifying event occurs; latency is one edge from sampling.
REQ-013 Active level is 1 for MODO 0 and 0 for MODO 1; MODO 2 has no active level and never repeats.
REQ-014 Each channel SHALL have a counter of width $clog2(max(RETARDO_REP,PERIODO_REP)+1), cleared on every edge impulse.
REQ-015 Repeat states per channel: LIBRE -> ESPERA on an edge impulse; ESPERA -> REPITE with impulse when the counter reaches RETARDO_REP-1; REPITE emits an impulse every PERIODO_REP cycles.
REQ-016 Leaving the active level in ESPERA or REPITE SHALL return the channel to LIBRE at once, with no impulse, including on a cycle where a repeat is due.
REQ-017 The counter SHALL saturate, never wrap, and SHALL be cleared on each repeat impulse.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels each produce their own impulse in the same cycle.

Reset
REQ-019 While reset=1 at a clock edge: impulso=0, cualquiera=0, valorAntiguo=0, counters=0, all channels in LIBRE.
REQ-020 Reset SHALL override any event sampled in the same cycle, including mid-repeat.
REQ-021 In MODO 0 or 2, an input held at 1 through reset release SHALL produce one impulse on the first edge after release.

Configuration
REQ-022 With macro AUTO_REPEAT_EN defined, REQ-013 to REQ-017 are implemented.
REQ-023 With AUTO_REPEAT_EN undefined, counters and repeat states are omitted, and only edge impulses occur.

Structure
REQ-024 Package detector_pkg SHALL hold MODO_SUBIDA=0, MODO_BAJADA=1, MODO_AMBOS=2 and the repeat-state encoding (LIBRE, ESPERA, REPITE).
REQ-025 Per-channel logic SHALL be sub-module canal_impulso, instantiated CANALES times via generate; cualquiera is built in the top level.

Verification
REQ-026 MODO 0, ch0: 0 to 1, held 3 cycles, released -> impulso[0]=1 for exactly one cycle, one edge after sampling.
REQ-027 MODO 1, ch2: 1 to 0 -> one impulse on ch2; 0 to 1 -> no impulse.
REQ-028 MODO 2, ch1 toggled twice 10 cycles apart -> two single-cycle impulses, no repeats while held.
REQ-029 AUTO_REPEAT_EN, RETARDO_REP=5, PERIODO_REP=3, ch3 held 15 cycles -> impulses at t, t+5, t+8, t+11, t+14; release at t+13 -> none at t+14.
REQ-030 ch0 and ch3 rise in the same cycle -> impulso=4'b1001, cualquiera=1 for that cycle.
REQ-031 reset asserted during REPITE with input held -> outputs 0 during reset; one impulse on the first edge after release (MODO 0).
